// File: rtl/cache_pipe_pkg.sv
// Shared definitions for the cache lookup -> control pipeline register chain:
// default widths, the default-width payload layout and width helpers.
package cache_pipe_pkg;

    localparam int DATA_W_DEF     = 256;
    localparam int ADDR_W_DEF     = 32;
    localparam int SET_W_DEF      = 3;
    localparam int WAYS_DEF       = 2;
    localparam int STAGES_DEF     = 2;
    localparam int STALL_HIST_DEF = 2;

    // Width of an index into n ways, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LRU_W_DEF = clog2_min1(WAYS_DEF);

    // Payload layout at the default widths, MSB first. The register chain
    // packs its fields in exactly this order for any parameterisation.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]            rdata;
        logic [DATA_W_DEF-1:0]            wdata;
        logic [ADDR_W_DEF-1:0]            addr;
        logic [SET_W_DEF-1:0]             set;
        logic [WAYS_DEF-1:0]              hit;
        logic                             dirty;
        logic [LRU_W_DEF-1:0]             lru;
        logic                             mem_write;
        logic                             load_cache;
        logic [WAYS_DEF*DATA_W_DEF/8-1:0] be_masked;
    } cache_pipe_payload_t;

    // Total packed payload width for a given parameterisation.
    function automatic int payload_w(input int dw, input int aw, input int sw, input int ways);
        return 2 * dw + aw + sw + ways + 1 + clog2_min1(ways) + 2 + ways * dw / 8;
    endfunction

endpackage

// File: rtl/cache_pipe_slot.sv
// One register slot of the chain: a valid bit plus a flat payload word.
// load_en captures d and sets valid; clear_en drops valid and wins over load.
module cache_pipe_slot
    import cache_pipe_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic         clear_en,
    input  logic [W-1:0] d,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state: payload only changes on load, so an unloaded slot holds everything.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_en) begin
            valid_d = 1'b1;
            data_d  = d;
        end
        if (clear_en) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cache_pipe_regs_n.sv
// Elastic STAGES-slot register chain carrying cache requests from tag/data
// lookup to control/writeback, with global stall, flush, a delayed-stall
// history and a valid-slot count.
// Optional: define CACHE_PIPE_LIVE_HIT_EN to refresh the held last slot's hit
// field from hit_live_i every cycle.
// Handshake: a transfer happens on a cycle where valid and ready are both high;
// valid never depends on ready, and a valid payload is held until it transfers
// (or a flush/reset drops it).
module cache_pipe_regs_n
    import cache_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int SET_W      = SET_W_DEF,
    parameter int WAYS       = WAYS_DEF,
    parameter int STAGES     = STAGES_DEF,
    parameter int STALL_HIST = STALL_HIST_DEF,
    localparam int LRU_W     = clog2_min1(WAYS),
    localparam int BE_W      = WAYS * DATA_W / 8,
    localparam int CNT_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [SET_W-1:0]      set_i,
    input  logic [WAYS-1:0]       hit_i,
    input  logic                  dirty_i,
    input  logic [LRU_W-1:0]      lru_i,
    input  logic                  mem_write_i,
    input  logic                  load_cache_i,
    input  logic [BE_W-1:0]       be_masked_i,
    input  logic [WAYS-1:0]       hit_live_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [SET_W-1:0]      set_o,
    output logic [WAYS-1:0]       hit_o,
    output logic                  dirty_o,
    output logic [LRU_W-1:0]      lru_o,
    output logic                  mem_write_o,
    output logic                  load_cache_o,
    output logic [BE_W-1:0]       be_masked_o,
    output logic [STALL_HIST-1:0] stall_hist_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int PW   = payload_w(DATA_W, ADDR_W, SET_W, WAYS);
    localparam int LAST = STAGES - 1;

    logic [PW-1:0]     in_pl;
    logic [PW-1:0]     held_pl;
    logic [PW-1:0]     pl [STAGES];
    logic [PW-1:0]     slot_d [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] slot_ld;
    logic [STAGES-1:0] slot_clr;
    logic [STAGES:0]   free;
    logic              live_upd;

    logic [STALL_HIST-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]      count_q, count_d;

    assign in_pl = {rdata_i, wdata_i, addr_i, set_i, hit_i, dirty_i, lru_i,
                    mem_write_i, load_cache_i, be_masked_i};

    assign {rdata_o, wdata_o, addr_o, set_o, hit_o, dirty_o, lru_o,
            mem_write_o, load_cache_o, be_masked_o} = pl[LAST];

`ifdef CACHE_PIPE_LIVE_HIT_EN
    // Last-slot payload with its hit field replaced by the live hit vector.
    assign held_pl = {rdata_o, wdata_o, addr_o, set_o, hit_live_i, dirty_o, lru_o,
                      mem_write_o, load_cache_o, be_masked_o};
`else
    logic unused_hit_live;
    assign unused_hit_live = ^hit_live_i;
    assign held_pl         = pl[LAST];
`endif

    // Ready chain and slot controls: free[k] means slot k empties or drains this
    // cycle, so bubbles collapse and a full chain moves one entry per cycle.
    always_comb begin
        free[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            free[k] = !v[k] || free[k+1];
        end
        live_upd = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                slot_ld[k]  = free[k] && in_valid && !stall_i && !flush_i;
                slot_clr[k] = flush_i || (free[k] && !in_valid && !stall_i);
                slot_d[k]   = in_pl;
            end else begin
                slot_ld[k]  = free[k] && v[k-1] && !stall_i && !flush_i;
                slot_clr[k] = flush_i || (free[k] && !v[k-1] && !stall_i);
                slot_d[k]   = pl[k-1];
            end
        end
`ifdef CACHE_PIPE_LIVE_HIT_EN
        live_upd = v[LAST] && !slot_ld[LAST];
        if (live_upd) begin
            slot_ld[LAST] = 1'b1;
            slot_d[LAST]  = held_pl;
        end
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        cache_pipe_slot #(.W(PW)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_en  (slot_ld[g]),
            .clear_en (slot_clr[g]),
            .d        (slot_d[g]),
            .valid_o  (v[g]),
            .data_o   (pl[g])
        );
    end

    // Next stall history and next valid-slot count, mirroring the slot controls.
    always_comb begin
        hist_d[0] = stall_i;
        for (int k = 1; k < STALL_HIST; k++) begin
            hist_d[k] = hist_q[k-1];
        end
        count_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (!slot_clr[k] && (slot_ld[k] || v[k])) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    // History and count registers, cleared asynchronously with the slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            count_q <= count_d;
        end
    end

    assign in_ready     = free[0] && !stall_i && !flush_i;
    assign out_valid    = v[LAST];
    assign stall_hist_o = hist_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_cache_pipe_regs_n.sv
// Bench for cache_pipe_regs_n at default parameters. The reference model sees
// the chain as an in-order queue of capacity STAGES that accepts unless it is
// full and blocked, empties on flush, and shifts a stall history register.
module tb_cache_pipe_regs_n;

    localparam int STAGES = 2;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 64;
    localparam int PW     = 2 * DATA_W + ADDR_W + 3 + 2 + 1 + 1 + 1 + 1 + BE_W;
    localparam int ADDR_LO = 73;
    localparam int HIT_LO  = 68;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     drv_pl = '0;
    logic [DATA_W-1:0] rdata_i, wdata_i, rdata_o, wdata_o;
    logic [ADDR_W-1:0] addr_i, addr_o;
    logic [2:0]        set_i, set_o;
    logic [1:0]        hit_i, hit_o;
    logic              dirty_i, dirty_o;
    logic              lru_i, lru_o;
    logic              mem_write_i, mem_write_o;
    logic              load_cache_i, load_cache_o;
    logic [BE_W-1:0]   be_masked_i, be_masked_o;
    logic [1:0]        hit_live_i = 2'b00;
    logic              stall_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        stall_hist_o;
    logic [1:0]        count_o;
    logic [PW-1:0]     out_pl;

    assign {rdata_i, wdata_i, addr_i, set_i, hit_i, dirty_i, lru_i,
            mem_write_i, load_cache_i, be_masked_i} = drv_pl;
    assign out_pl = {rdata_o, wdata_o, addr_o, set_o, hit_o, dirty_o, lru_o,
                     mem_write_o, load_cache_o, be_masked_o};

    cache_pipe_regs_n dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rdata_i      (rdata_i),
        .wdata_i      (wdata_i),
        .addr_i       (addr_i),
        .set_i        (set_i),
        .hit_i        (hit_i),
        .dirty_i      (dirty_i),
        .lru_i        (lru_i),
        .mem_write_i  (mem_write_i),
        .load_cache_i (load_cache_i),
        .be_masked_i  (be_masked_i),
        .hit_live_i   (hit_live_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rdata_o      (rdata_o),
        .wdata_o      (wdata_o),
        .addr_o       (addr_o),
        .set_o        (set_o),
        .hit_o        (hit_o),
        .dirty_o      (dirty_o),
        .lru_o        (lru_o),
        .mem_write_o  (mem_write_o),
        .load_cache_o (load_cache_o),
        .be_masked_o  (be_masked_o),
        .stall_hist_o (stall_hist_o),
        .count_o      (count_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard state
    logic [PW-1:0] exp_q[$];
    int            cyc_q[$];
    logic [1:0]    hist_m = 2'b00;
    int            cycle = 0;
    bit            lat_chk = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic void chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compares against the model, then advances the model across the coming edge.
    always @(negedge clk) begin
        logic exp_rdy;
        logic [PW-1:0] front;
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            hist_m = 2'b00;
        end else begin
            exp_rdy = ((exp_q.size() < STAGES) || out_ready) && !stall_i && !flush_i;
            chk("in_ready", PW'(in_ready), PW'(exp_rdy));
            chk("count_o", PW'(count_o), PW'(exp_q.size()));
            chk("stall_hist_o", PW'(stall_hist_o), PW'(hist_m));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_valid: got 1 expected 0 (nothing in flight), addr %0h", addr_o);
                end else if (out_ready && !stall_i) begin
                    front = exp_q.pop_front();
                    chk("payload", out_pl, front);
                    if (lat_chk) begin
                        chk("latency", PW'(cycle - cyc_q[0]), PW'(STAGES));
                    end
                    void'(cyc_q.pop_front());
                end else begin
`ifdef CACHE_PIPE_LIVE_HIT_EN
                    exp_q[0][HIT_LO +: 2] = hit_live_i;
`endif
                end
            end
            if (flush_i) begin
                exp_q.delete();
                cyc_q.delete();
            end
            if (exp_rdy && in_valid) begin
                exp_q.push_back(drv_pl);
                cyc_q.push_back(cycle);
            end
            hist_m = {hist_m[0], stall_i};
        end
        cycle++;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input logic [31:0] a);
        logic [PW+31:0] tmp;
        for (int i = 0; i < (PW + 31) / 32; i++) begin
            tmp[i*32 +: 32] = $urandom;
        end
        drv_pl = tmp[PW-1:0];
        drv_pl[ADDR_LO +: 32] = a;
    endtask

    task automatic send(input logic [31:0] a);
        rand_payload(a);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [31:0] frozen;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset out_valid", PW'(out_valid), '0);
        chk("reset payload", out_pl, '0);
        tick();

        // Throughput: three back-to-back requests, each exactly STAGES cycles later.
        out_ready = 1'b1;
        lat_chk = 1'b1;
        rand_payload(32'h100); in_valid = 1'b1; tick();
        rand_payload(32'h120); tick();
        rand_payload(32'h140); tick();
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure: fill, confirm full and blocked, then drain in order.
        out_ready = 1'b0;
        send(32'h200);
        send(32'h220);
        chk("bp count_o", PW'(count_o), PW'(2));
        chk("bp in_ready", PW'(in_ready), '0);
        drain();
        chk("held addr_o", PW'(addr_o), PW'(32'h220));

        // Stall on a full chain: payload frozen, history shifts.
        out_ready = 1'b0;
        send(32'h240);
        send(32'h260);
        out_ready = 1'b1;
        stall_i = 1'b1;
        frozen = addr_o;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall addr_o", PW'(addr_o), PW'(frozen));
        end
        stall_i = 1'b0;
        tick();
        chk("hist after stall", PW'(stall_hist_o), PW'(2'b10));
        drain();

        // Flush on a full chain with a competing input.
        out_ready = 1'b0;
        send(32'h280);
        send(32'h2a0);
        rand_payload(32'h300);
        in_valid = 1'b1;
        flush_i = 1'b1;
        tick();
        in_valid = 1'b0;
        flush_i = 1'b0;
        chk("flush count_o", PW'(count_o), '0);
        chk("flush out_valid", PW'(out_valid), '0);
        drain();

        // Held miss with a changing live hit vector.
        out_ready = 1'b0;
        rand_payload(32'h320);
        drv_pl[HIT_LO +: 2] = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        hit_live_i = 2'b10;
        tick();
`ifdef CACHE_PIPE_LIVE_HIT_EN
        chk("live hit_o", PW'(hit_o), PW'(2'b10));
`else
        chk("live hit_o", PW'(hit_o), PW'(2'b00));
`endif
        hit_live_i = 2'b00;
        drain();

        // Asynchronous reset with two entries in flight and a stall in the history.
        out_ready = 1'b0;
        send(32'h340);
        send(32'h360);
        stall_i = 1'b1;
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", PW'(out_valid), '0);
        chk("mid reset count_o", PW'(count_o), '0);
        chk("mid reset hist", PW'(stall_hist_o), '0);
        chk("mid reset addr_o", PW'(addr_o), '0);
        stall_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("post reset in_ready", PW'(in_ready), PW'(1'b1));
        tick();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rand_payload($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            stall_i   = ($urandom_range(0, 7) == 0);
            flush_i   = ($urandom_range(0, 39) == 0);
            hit_live_i = 2'($urandom_range(0, 3));
            tick();
        end
        hit_live_i = 2'b00;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_pipe_regs_n.md
Name: cache_pipe_regs_n

Overview:
- Parametrised, elastic pipeline-register chain between the cache tag/data lookup and the cache control/writeback stages.
- Carries the cache request payload through STAGES register slots with per-slot valid/ready handshake, global stall, and flush.
- Also provides a STALL_HIST-deep delayed-stall history and a slot occupancy count.
- Generalises the fixed single-slot cache stage register to N ways, N slots and N stall-delay taps.

Parameters:
- DATA_W, 256, cache line width in bits.
- ADDR_W, 32, request address width.
- SET_W, 3, set index width.
- WAYS, 2, associativity. Sets the widths of the hit vector, LRU and byte-enable fields.
- STAGES, 2, number of register slots; legal values 1..8.
- STALL_HIST, 2, number of delayed stall taps; legal values 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  slot 0 can accept
- rdata_i  in  DATA_W  line read from cache
- wdata_i  in  DATA_W  line write data from CPU side
- addr_i  in  ADDR_W  request address
- set_i  in  SET_W  set index
- hit_i  in  WAYS  per-way hit vector
- dirty_i  in  1  victim dirty
- lru_i  in  max(1,$clog2(WAYS))  LRU way
- mem_write_i  in  1  write request
- load_cache_i  in  1  line load request
- be_masked_i  in  WAYS*DATA_W/8  per-way masked byte enables
- hit_live_i  in  WAYS  live hit vector; used only with the optional feature
- stall_i  in  1  global hold
- flush_i  in  1  kill all in-flight entries
- out_valid  out  1  last slot valid
- out_ready  in  1  downstream accepts
- rdata_o, wdata_o, addr_o, set_o, hit_o, dirty_o, lru_o, mem_write_o, load_cache_o, be_masked_o  out  widths as the corresponding inputs  last-slot payload
- stall_hist_o  out  STALL_HIST  bit k = stall_i delayed by k+1 cycles
- count_o  out  $clog2(STAGES+1)  number of valid slots

Behaviour:
- Reset (async, active-high):
  - All slot valid bits and payload registers go to 0, so out_valid=0 and all payload outputs are 0.
  - stall_hist_o=0 and count_o=0.
  - in_ready evaluates combinationally to 1 once rst deasserts, provided stall_i=0 and flush_i=0.
  - Reset mid-transfer drops all entries; there is no replay.
- Slot advance:
  - adv[last] = out_valid & out_ready & !stall_i.
  - Slot k loads when !v[k] | adv[k+1]. The ready chain is combinational, so a full pipe sustains one transfer per cycle.
- in_ready = (!v[0] | adv[1]) & !stall_i & !flush_i. For STAGES=1, adv[1] means adv[last].
- Input transfer = in_valid & in_ready. Latency from input transfer to out_valid is exactly STAGES cycles when not blocked.
- Payload hold:
  - Holds are strict: a slot that does not load keeps all fields, including hit.
  - Payload outputs always show the last slot, even when out_valid=0.
- Stall:
  - No slot loads, out_valid is unchanged, no transfer occurs, and in_ready=0.
  - stall_hist_o keeps shifting every cycle regardless of stall: hist[0]<=stall_i, hist[k]<=hist[k-1].
- Flush:
  - All valid bits clear on the next edge; payload registers are untouched.
  - Flush dominates stall and in_valid in the same cycle: nothing is accepted.
  - An output transfer in the flush cycle still completes (out_valid & out_ready & !stall_i).
- Bubbles collapse: an empty slot loads from an upstream valid slot even if downstream is blocked.
- count_o is the popcount of the valid bits, registered consistently with them.
- out_valid must not depend combinationally on out_ready.

Optional Feature:
- Macro: CACHE_PIPE_LIVE_HIT_EN.
- Defined: while the last slot is valid and does not load, its hit field reloads from hit_live_i every cycle, including during stall. This lets a refill resolve a held miss into a hit.
- Undefined: hit is captured only at slot load, and hit_live_i is ignored.

Decomposition:
- Shared package cache_pipe_pkg holds:
  - default width localparams;
  - typedef cache_pipe_payload_t, a packed struct of all payload fields;
  - function clog2_min1 for the lru_o width.
- One sub-module, cache_pipe_slot: a single valid+payload register with load/clear controls, instantiated STAGES times in a generate loop.

Test Plan:
- Reset: assert rst mid-stream with 2 entries in flight → out_valid=0, count_o=0 and stall_hist_o=0 asynchronously; in_ready=1 after release.
- Throughput: STAGES=2, out_ready=1, issue addr 0x100, 0x120, 0x140 on consecutive cycles → each appears at out_valid exactly 2 cycles later, back-to-back, with no bubbles.
- Backpressure: out_ready=0 with addrs 0x200 and 0x220 sent → count_o=2 and in_ready=0; raise out_ready → 0x200 then 0x220 drain in order with payloads intact.
- Stall plus history: stall_i high for 3 cycles with pipe full → no transfers, payload frozen; stall_hist_o sequence shows 01, 11, 11, 10, 00 relative to stall edges.
- Flush: full pipe, flush_i=1 with in_valid=1 and addr 0x300 → next cycle count_o=0 and out_valid=0; 0x300 never appears at the output.
- Live hit (macro defined): last slot holds hit=2'b00 with out_ready=0, drive hit_live_i=2'b10 → hit_o=2'b10 the next cycle. With the macro undefined, hit_o stays 2'b00.
